tm_filter_sequencer: RTL and testbench

//  Control sequencer for the time-multiplexed FIR datapath: one shared MAC walks N taps for each of CH channels.

---
 rtl/tm_filter_pkg.sv | 18 +
 rtl/tm_mod_counter.sv | 30 +++
 rtl/tm_filter_sequencer.sv | 113 +++++++++++
 tb/tb_tm_filter_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tm_filter_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
// No logic of its own; no latency.
// No handshake of its own; no backpressure.
package tm_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Index width for a counter of n values. This never returns 0, so a
  // single-value counter still gets a legal one-bit port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tm_mod_counter.sv
// Modulo-MOD up counter with synchronous clear and a terminal-count flag.
// The count updates one cycle after inc; last is combinational from the count.
// No handshake of its own; it advances only when the parent asserts inc.
module tm_mod_counter
  import tm_filter_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = clog2_min1(MOD)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         last
);

  assign last = (value == W'(MOD - 1));

  // The count wraps explicitly at MOD-1. It never relies on binary rollover.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      value <= '0;
    else if (clr)
      value <= '0;
    else if (inc)
      value <= last ? '0 : value + W'(1);
  end

endmodule

// File: rtl/tm_filter_sequencer.sv
// Drives one shared MAC across N taps for each of CH channels per accepted sample vector.
// The first result is valid N+1 cycles after accept. The period is CH*(N+1)+1 cycles with out_ready held high.
// in_ready is high only in IDLE. Without out_ready, OUT holds indefinitely and every output stays stable.
module tm_filter_sequencer
  import tm_filter_pkg::*;
#(
  parameter int N      = 3,
  parameter int CH     = 2,
  parameter int ONEHOT = 1,
  localparam int TW    = clog2_min1(N),
  localparam int CW    = clog2_min1(CH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          xSEL,
  output logic [N-1:0]  muxSEL,
  output logic [TW-1:0] tapIdx,
  output logic [CW-1:0] chIdx,
  output logic          accCLR,
  output logic          accEN,
  output logic          outSEL,
  output logic          busy
);

  state_e state_q, state_d;
  logic   rdy_q;
  logic   in_fire;
  logic   tap_last, ch_last;
  logic   tap_inc, ch_inc;

  assign in_fire = in_valid & rdy_q & (state_q == ST_IDLE);
  assign tap_inc = (state_q == ST_MAC);
  assign ch_inc  = (state_q == ST_OUT) & out_ready;

  // The tap counter advances on every MAC cycle and wraps to 0 on the last tap.
  tm_mod_counter #(.MOD(N), .W(TW)) u_tap (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (tap_inc),
    .clr   (in_fire),
    .value (tapIdx),
    .last  (tap_last)
  );

  // The channel counter advances when a result is taken and wraps to 0 after the last channel.
  tm_mod_counter #(.MOD(CH), .W(CW)) u_ch (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (ch_inc),
    .clr   (in_fire),
    .value (chIdx),
    .last  (ch_last)
  );

  // rdy_q keeps in_ready low through reset and during the first cycle after reset release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      rdy_q <= 1'b0;
    else
      rdy_q <= 1'b1;
  end

  // State register. A reset aborts any MAC or OUT phase in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic and Moore decode. xSEL is the only output that depends on an input.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    xSEL      = 1'b0;
    muxSEL    = '0;
    accCLR    = 1'b0;
    accEN     = 1'b0;
    out_valid = 1'b0;
    outSEL    = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        in_ready = rdy_q;
        xSEL     = in_valid & rdy_q;
        if (in_valid && rdy_q)
          state_d = ST_MAC;
      end
      ST_MAC: begin
        accEN  = 1'b1;
        accCLR = (tapIdx == '0);
        if (ONEHOT != 0)
          muxSEL = N'(1) << tapIdx;
        else
          muxSEL = N'(tapIdx);
        if (tap_last)
          state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        outSEL    = 1'b1;
        if (out_ready)
          state_d = ch_last ? ST_IDLE : ST_MAC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tm_filter_sequencer.sv
// Directed bench for tm_filter_sequencer covering three parameter sets on a shared clock and reset.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
// Every sequence has a fixed length, so the bench always terminates.
module tb_tm_filter_sequencer;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Instance a: N=3, CH=2, one-hot select.
  logic       iv_a, or_a, ir_a, ov_a, xs_a, clr_a, en_a, os_a, busy_a;
  logic [2:0] mux_a;
  logic [1:0] tap_a;
  logic       ch_a;

  tm_filter_sequencer #(.N(3), .CH(2), .ONEHOT(1)) dut_a (
    .CLK(CLK), .RST(RST), .in_valid(iv_a), .in_ready(ir_a), .out_ready(or_a),
    .out_valid(ov_a), .xSEL(xs_a), .muxSEL(mux_a), .tapIdx(tap_a), .chIdx(ch_a),
    .accCLR(clr_a), .accEN(en_a), .outSEL(os_a), .busy(busy_a)
  );

  // Instance b: N=5, CH=1, binary select.
  logic       iv_b, or_b, ir_b, ov_b, xs_b, clr_b, en_b, os_b, busy_b;
  logic [4:0] mux_b;
  logic [2:0] tap_b;
  logic       ch_b;

  tm_filter_sequencer #(.N(5), .CH(1), .ONEHOT(0)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(iv_b), .in_ready(ir_b), .out_ready(or_b),
    .out_valid(ov_b), .xSEL(xs_b), .muxSEL(mux_b), .tapIdx(tap_b), .chIdx(ch_b),
    .accCLR(clr_b), .accEN(en_b), .outSEL(os_b), .busy(busy_b)
  );

  // Instance c: N=1, CH=1.
  logic       iv_c, or_c, ir_c, ov_c, xs_c, clr_c, en_c, os_c, busy_c;
  logic [0:0] mux_c;
  logic [0:0] tap_c;
  logic       ch_c;

  tm_filter_sequencer #(.N(1), .CH(1), .ONEHOT(1)) dut_c (
    .CLK(CLK), .RST(RST), .in_valid(iv_c), .in_ready(ir_c), .out_ready(or_c),
    .out_valid(ov_c), .xSEL(xs_c), .muxSEL(mux_c), .tapIdx(tap_c), .chIdx(ch_c),
    .accCLR(clr_c), .accEN(en_c), .outSEL(os_c), .busy(busy_c)
  );

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       irdy;
    logic       xsel;
    logic [2:0] mux;
    logic [1:0] tap;
    logic       ch;
    logic       clr;
    logic       en;
    logic       ov;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic ordy, logic irdy, logic xsel, logic [2:0] mux,
                              logic [1:0] tap, logic ch, logic clr, logic en, logic ov,
                              logic busy);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.irdy = irdy; v.xsel = xsel; v.mux = mux; v.tap = tap;
    v.ch = ch; v.clr = clr; v.en = en; v.ov = ov; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Output bundle of instance a: in_ready, xSEL, muxSEL, tapIdx, chIdx, accCLR, accEN, out_valid, outSEL, busy.
  function automatic logic [12:0] bundle_a();
    return {ir_a, xs_a, mux_a, tap_a, ch_a, clr_a, en_a, ov_a, os_a, busy_a};
  endfunction

  function automatic logic [12:0] bundle_exp(vec_t v);
    return {v.irdy, v.xsel, v.mux, v.tap, v.ch, v.clr, v.en, v.ov, v.ov, v.busy};
  endfunction

  int xcount;

  initial begin
    // Reset state: every output reads 0 during reset, even with in_valid high.
    RST = 1'b0;
    iv_a = 1'b1; or_a = 1'b1;
    iv_b = 1'b0; or_b = 1'b1;
    iv_c = 1'b0; or_c = 1'b1;
    next_cycle();
    next_cycle();
    check("reset_outputs_a", 32'(bundle_a()), 32'h0);
    check("reset_inready_bc", {30'd0, ir_b, ir_c}, 32'h0);
    iv_a = 1'b0;
    RST  = 1'b1;
    next_cycle();

    // Accept, then both channels with out_ready high.
    //         iv ordy irdy xsel mux     tap ch clr en ov busy
    vecs.push_back(mk(1, 1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0)); // c0 accept
    vecs.push_back(mk(0, 1, 0, 0, 3'b001, 0, 0, 1, 1, 0, 1)); // c1
    vecs.push_back(mk(0, 1, 0, 0, 3'b010, 1, 0, 0, 1, 0, 1)); // c2
    vecs.push_back(mk(0, 1, 0, 0, 3'b100, 2, 0, 0, 1, 0, 1)); // c3
    vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c4 out ch0
    vecs.push_back(mk(0, 1, 0, 0, 3'b001, 0, 1, 1, 1, 0, 1)); // c5
    vecs.push_back(mk(0, 1, 0, 0, 3'b010, 1, 1, 0, 1, 0, 1)); // c6
    vecs.push_back(mk(0, 1, 0, 0, 3'b100, 2, 1, 0, 1, 0, 1)); // c7
    vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 1, 1)); // c8 out ch1
    vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0)); // c9 idle
    // Same pass with a stall on ch0's result for c4-c8; in_valid pulses mid-stall.
    vecs.push_back(mk(1, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0)); // c0
    vecs.push_back(mk(0, 0, 0, 0, 3'b001, 0, 0, 1, 1, 0, 1)); // c1
    vecs.push_back(mk(0, 0, 0, 0, 3'b010, 1, 0, 0, 1, 0, 1)); // c2
    vecs.push_back(mk(0, 0, 0, 0, 3'b100, 2, 0, 0, 1, 0, 1)); // c3
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c4 stall
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c5
    vecs.push_back(mk(1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c6 in_valid ignored
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c7
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c8
    vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1)); // c9 released
    vecs.push_back(mk(0, 1, 0, 0, 3'b001, 0, 1, 1, 1, 0, 1)); // c10
    vecs.push_back(mk(0, 1, 0, 0, 3'b010, 1, 1, 0, 1, 0, 1)); // c11
    vecs.push_back(mk(0, 1, 0, 0, 3'b100, 2, 1, 0, 1, 0, 1)); // c12
    vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 1, 1)); // c13 out ch1
    vecs.push_back(mk(0, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0)); // c14 idle

    for (int i = 0; i < vecs.size(); i++) begin
      iv_a = vecs[i].iv;
      or_a = vecs[i].ordy;
      @(negedge CLK);
      check($sformatf("vec%0d", i), 32'(bundle_a()), 32'(bundle_exp(vecs[i])));
      next_cycle();
    end

    // in_valid held high: exactly one accept per 9-cycle period.
    iv_a = 1'b1; or_a = 1'b1; xcount = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge CLK);
      if (xs_a) xcount++;
      check($sformatf("hold_xsel%0d", i), {31'd0, xs_a}, {31'd0, (i % 9) == 0});
      next_cycle();
    end
    check("hold_xsel_count", 32'(xcount), 32'd3);
    iv_a = 1'b0;

    // Binary select, N=5: muxSEL and tapIdx step 0..4.
    iv_b = 1'b1;
    @(negedge CLK);
    check("b_accept", {30'd0, xs_b, ir_b}, 32'h3);
    next_cycle();
    iv_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("b_mux%0d", k), 32'(mux_b), 32'(k));
      check($sformatf("b_tap%0d", k), 32'(tap_b), 32'(k));
      check($sformatf("b_clr%0d", k), {30'd0, clr_b, en_b}, {30'd0, k == 0, 1'b1});
      next_cycle();
    end
    @(negedge CLK);
    check("b_out", {29'd0, ov_b, os_b, mux_b == 5'd0}, 32'h7);
    next_cycle();
    @(negedge CLK);
    check("b_idle", {30'd0, ir_b, busy_b}, 32'h2);

    // N=1, CH=1 back-to-back: accept, MAC, OUT, repeating every 3 cycles.
    next_cycle();
    iv_c = 1'b1; or_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      case (i % 3)
        0: check($sformatf("c_ph%0d", i), {27'd0, xs_c, clr_c, en_c, ov_c, mux_c}, 32'h10);
        1: check($sformatf("c_ph%0d", i), {27'd0, xs_c, clr_c, en_c, ov_c, mux_c}, 32'h0D);
        default: check($sformatf("c_ph%0d", i), {27'd0, xs_c, clr_c, en_c, ov_c, mux_c}, 32'h02);
      endcase
      next_cycle();
    end
    iv_c = 1'b0;
    next_cycle();
    next_cycle();

    // Reset asserted in the middle of MAC (tap=1) aborts at once.
    iv_a = 1'b1; or_a = 1'b1;
    next_cycle();
    iv_a = 1'b0;
    next_cycle();
    @(negedge CLK);
    check("pre_reset_tap", 32'(tap_a), 32'd1);
    RST = 1'b0;
    #1;
    check("midmac_reset", {27'd0, mux_a, ov_a, ir_a}, 32'h0);
    check("midmac_reset_busy_tap", {29'd0, busy_a, tap_a}, 32'h0);
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    check("release_inready_low", {31'd0, ir_a}, 32'h0);
    next_cycle();
    @(negedge CLK);
    check("release_inready_high", {30'd0, ir_a, busy_a}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("no_partial%0d", i), {30'd0, ov_a, os_a}, 32'h0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
